// File: rtl/dma_bus_pkg.sv
// Shared types and widths for the DMA bus-ownership arbiter.
package dma_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HLDA,
    GRANT,
    RELEASE
  } bus_state_e;

  localparam int unsigned GAP_W    = 4;
  localparam int unsigned TENURE_W = 16;

endpackage

// File: rtl/dma_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward
// from rr_ptr, wrapping modulo N_MASTERS.
module dma_rr_pick #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned W         = $clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] hrq,
  input  logic [W-1:0]         rr_ptr,
  output logic [W-1:0]         winner,
  output logic                 valid
);

  localparam logic [W:0] NM = (W+1)'(N_MASTERS);

  logic [W:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      idx = {1'b0, rr_ptr} + (W+1)'(i);
      if (idx >= NM) idx = idx - NM;
      if (!valid && hrq[idx[W-1:0]]) begin
        valid  = 1'b1;
        winner = idx[W-1:0];
      end
    end
  end

endmodule

// File: rtl/dma_bus_arbiter.sv
// HOLD/HLDA sequencer granting the bus to one of N DMA masters round-robin.
// Optional tenure limit enabled by defining DMA_BUS_TENURE_LIMIT_EN.
module dma_bus_arbiter
  import dma_bus_pkg::*;
#(
  parameter int unsigned N_MASTERS  = 2,
  parameter int unsigned IDLE_GAP   = 1,
  parameter int unsigned MAX_TENURE = 256
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [N_MASTERS-1:0]         hrq,
  input  logic                         cpu_hlda,
  output logic                         cpu_hold,
  output logic [N_MASTERS-1:0]         hlda,
  output logic [$clog2(N_MASTERS)-1:0] owner,
  output logic                         busy,
  output logic                         proto_err
`ifdef DMA_BUS_TENURE_LIMIT_EN
  ,
  output logic                         tenure_expired
`endif
);

  localparam int unsigned W = $clog2(N_MASTERS);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(IDLE_GAP);

  bus_state_e           state, state_nxt;
  logic                 hold_nxt, busy_nxt, perr_nxt;
  logic [N_MASTERS-1:0] hlda_nxt;
  logic [W-1:0]         owner_nxt, rr_ptr, rr_nxt, owner_inc;
  logic [GAP_W-1:0]     gap, gap_nxt;
  logic [W-1:0]         pick;
  logic                 pick_valid;
  logic                 grant_exit;
  logic                 expired;

`ifdef DMA_BUS_TENURE_LIMIT_EN
  logic [TENURE_W-1:0]  tcnt, tcnt_nxt;
  logic                 texp_nxt;
  assign expired = (tcnt == TENURE_W'(MAX_TENURE - 1));
`else
  logic                 tenure_unused;
  assign tenure_unused = (MAX_TENURE != 0);
  assign expired = 1'b0;
`endif

  dma_rr_pick #(
    .N_MASTERS(N_MASTERS),
    .W        (W)
  ) u_pick (
    .hrq   (hrq),
    .rr_ptr(rr_ptr),
    .winner(pick),
    .valid (pick_valid)
  );

  assign owner_inc  = (owner == W'(N_MASTERS - 1)) ? '0 : owner + 1'b1;
  // Any of the three GRANT exits (withdrawal, CPU violation, expiry) share one path.
  assign grant_exit = !hrq[owner] || !cpu_hlda || expired;

  always_comb begin
    state_nxt = state;
    hold_nxt  = cpu_hold;
    hlda_nxt  = hlda;
    owner_nxt = owner;
    perr_nxt  = proto_err;
    rr_nxt    = rr_ptr;
    gap_nxt   = gap;
`ifdef DMA_BUS_TENURE_LIMIT_EN
    tcnt_nxt  = tcnt;
    texp_nxt  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (gap != '0) begin
          gap_nxt = gap - 1'b1;
        end else if (pick_valid) begin
          owner_nxt = pick;
          hold_nxt  = 1'b1;
          state_nxt = WAIT_HLDA;
        end
      end
      WAIT_HLDA: begin
        if (!hrq[owner]) begin
          hold_nxt  = 1'b0;
          state_nxt = RELEASE;
        end else if (cpu_hlda) begin
          hlda_nxt        = '0;
          hlda_nxt[owner] = 1'b1;
          state_nxt       = GRANT;
`ifdef DMA_BUS_TENURE_LIMIT_EN
          tcnt_nxt        = '0;
`endif
        end
      end
      GRANT: begin
        if (grant_exit) begin
          hlda_nxt  = '0;
          hold_nxt  = 1'b0;
          rr_nxt    = owner_inc;
          state_nxt = RELEASE;
          if (hrq[owner] && !cpu_hlda) perr_nxt = 1'b1;
`ifdef DMA_BUS_TENURE_LIMIT_EN
          if (hrq[owner] && cpu_hlda) texp_nxt = 1'b1;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
`endif
        end
      end
      RELEASE: begin
        hold_nxt = 1'b0;
        hlda_nxt = '0;
        if (!cpu_hlda) begin
          gap_nxt   = GAP_INIT;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      cpu_hold  <= 1'b0;
      hlda      <= '0;
      owner     <= '0;
      busy      <= 1'b0;
      proto_err <= 1'b0;
      rr_ptr    <= '0;
      gap       <= '0;
    end else begin
      state     <= state_nxt;
      cpu_hold  <= hold_nxt;
      hlda      <= hlda_nxt;
      owner     <= owner_nxt;
      busy      <= busy_nxt;
      proto_err <= perr_nxt;
      rr_ptr    <= rr_nxt;
      gap       <= gap_nxt;
    end
  end

`ifdef DMA_BUS_TENURE_LIMIT_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tcnt           <= '0;
      tenure_expired <= 1'b0;
    end else begin
      tcnt           <= tcnt_nxt;
      tenure_expired <= texp_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed self-checking bench for dma_bus_arbiter (N_MASTERS=2, IDLE_GAP=1).
module tb_dma_bus_arbiter;

  localparam int unsigned N_MASTERS  = 2;
  localparam int unsigned IDLE_GAP   = 1;
  localparam int unsigned MAX_TENURE = 8;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] hrq;
  logic       cpu_hlda;
  logic       cpu_hold;
  logic [1:0] hlda;
  logic       owner;
  logic       busy;
  logic       proto_err;
`ifdef DMA_BUS_TENURE_LIMIT_EN
  logic       tenure_expired;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  dma_bus_arbiter #(
    .N_MASTERS (N_MASTERS),
    .IDLE_GAP  (IDLE_GAP),
    .MAX_TENURE(MAX_TENURE)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .hrq      (hrq),
    .cpu_hlda (cpu_hlda),
    .cpu_hold (cpu_hold),
    .hlda     (hlda),
    .owner    (owner),
    .busy     (busy),
    .proto_err(proto_err)
`ifdef DMA_BUS_TENURE_LIMIT_EN
    ,
    .tenure_expired(tenure_expired)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_hold(input string tag);
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (cpu_hold) return;
    end
    check(tag, 32'(cpu_hold), 32'd1);
  endtask

  // Safety invariants: hlda one-hot-or-zero, never without cpu_hold.
  always @(negedge CLK) begin
    if (!RESET)
      check("inv", 32'((hlda != 2'b00 && !cpu_hold) || $countones(hlda) > 1), 32'd0);
  end

  initial begin
    logic [1:0] exp_g;
    int         idle;
    logic       got_hold;
`ifdef DMA_BUS_TENURE_LIMIT_EN
    int         gcnt;
    int         ecnt;
`endif
    RESET    = 1'b1;
    hrq      = 2'b00;
    cpu_hlda = 1'b0;
    cyc(2);
    RESET = 1'b0;
    check("rst_hold",  32'(cpu_hold),  32'd0);
    check("rst_hlda",  32'(hlda),      32'd0);
    check("rst_owner", 32'(owner),     32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_perr",  32'(proto_err), 32'd0);

    // Single request, CPU acknowledges 2 cycles after cpu_hold
    hrq = 2'b01;
    cyc(1);
    check("t1_hold",  32'(cpu_hold), 32'd1);
    check("t1_owner", 32'(owner),    32'd0);
    check("t1_busy",  32'(busy),     32'd1);
    cyc(1);
    check("t1_nohlda", 32'(hlda), 32'd0);
    cpu_hlda = 1'b1;
    cyc(1);
    check("t1_hlda", 32'(hlda), 32'd1);
    cyc(1);
    check("t1_hlda2", 32'(hlda), 32'd1);
    hrq = 2'b00;
    cyc(1);
    check("t1_drop_hlda", 32'(hlda),     32'd0);
    check("t1_drop_hold", 32'(cpu_hold), 32'd0);
    check("t1_rel_busy",  32'(busy),     32'd1);
    cpu_hlda = 1'b0;
    cyc(1);
    check("t1_idle", 32'(busy), 32'd0);

    // Simultaneous requests alternate starting from master 1 (rr_ptr=1)
    hrq  = 2'b11;
    idle = 0;
    for (int t = 0; t < 4; t++) begin
      exp_g    = (t % 2 == 0) ? 2'b10 : 2'b01;
      got_hold = 1'b0;
      for (int k = 0; k < 20 && !got_hold; k++) begin
        @(negedge CLK);
        if (cpu_hold) got_hold = 1'b1;
        else if (!busy) idle++;
      end
      check("rr_hold", 32'(got_hold), 32'd1);
      check("rr_gap", 32'(idle >= int'(IDLE_GAP)), 32'd1);
      cpu_hlda = 1'b1;
      cyc(1);
      check("rr_grant", 32'(hlda), 32'(exp_g));
      hrq = hrq & ~exp_g;
      cyc(1);
      check("rr_drop", 32'({hlda, cpu_hold}), 32'd0);
      cpu_hlda = 1'b0;
      hrq      = 2'b11;
      idle     = 0;
    end
    hrq = 2'b00;
    cyc(3);

    // Withdrawal during WAIT_HLDA; RELEASE holds until cpu_hlda falls
    hrq = 2'b01;
    wait_hold("wd_hold_timeout");
    hrq      = 2'b00;
    cpu_hlda = 1'b1;
    cyc(1);
    check("wd_hold", 32'(cpu_hold), 32'd0);
    check("wd_hlda", 32'(hlda),     32'd0);
    check("wd_busy", 32'(busy),     32'd1);
    cyc(1);
    check("wd_busy2", 32'(busy), 32'd1);
    check("wd_hlda2", 32'(hlda), 32'd0);
    cpu_hlda = 1'b0;
    cyc(1);
    check("wd_idle", 32'(busy), 32'd0);
    cyc(3);

    // CPU drops cpu_hlda mid-GRANT
    hrq = 2'b01;
    wait_hold("pv_hold_timeout");
    cpu_hlda = 1'b1;
    cyc(1);
    check("pv_grant", 32'(hlda), 32'd1);
    cpu_hlda = 1'b0;
    cyc(1);
    check("pv_hlda", 32'(hlda),      32'd0);
    check("pv_hold", 32'(cpu_hold),  32'd0);
    check("pv_perr", 32'(proto_err), 32'd1);
    hrq = 2'b00;
    cyc(4);
    check("pv_sticky", 32'(proto_err), 32'd1);
    check("pv_idle",   32'(busy),      32'd0);

    // Asynchronous reset mid-GRANT
    hrq = 2'b01;
    wait_hold("ar_hold_timeout");
    cpu_hlda = 1'b1;
    cyc(1);
    check("ar_grant", 32'(hlda), 32'd1);
    #2 RESET = 1'b1;
    #1;
    check("ar_hold",  32'(cpu_hold),  32'd0);
    check("ar_hlda",  32'(hlda),      32'd0);
    check("ar_busy",  32'(busy),      32'd0);
    check("ar_perr",  32'(proto_err), 32'd0);
    check("ar_owner", 32'(owner),     32'd0);
    hrq      = 2'b00;
    cpu_hlda = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    hrq   = 2'b10;
    cyc(1);
    check("ar_rehold", 32'(cpu_hold), 32'd1);
    check("ar_owner1", 32'(owner),    32'd1);
    cpu_hlda = 1'b1;
    cyc(1);
    check("ar_regrant", 32'(hlda), 32'd2);
    hrq = 2'b00;
    cyc(1);
    check("ar_drop", 32'(hlda), 32'd0);
    cpu_hlda = 1'b0;
    cyc(3);

`ifdef DMA_BUS_TENURE_LIMIT_EN
    // Tenure limit with hrq held high
    hrq = 2'b01;
    wait_hold("tl_hold_timeout");
    cpu_hlda = 1'b1;
    gcnt = 0;
    ecnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge CLK);
      if (tenure_expired) ecnt++;
      if (hlda != 2'b00) gcnt++;
      else if (gcnt > 0) break;
    end
    check("tl_len",  32'(gcnt),     32'(MAX_TENURE));
    check("tl_exp",  32'(ecnt),     32'd1);
    check("tl_hold", 32'(cpu_hold), 32'd0);
    cpu_hlda = 1'b0;
    cyc(1);
    check("tl_pulse", 32'(tenure_expired), 32'd0);
    wait_hold("tl_rehold_timeout");
    cpu_hlda = 1'b1;
    cyc(1);
    check("tl_regrant", 32'(hlda), 32'd1);
    hrq = 2'b00;
    cyc(1);
    cpu_hlda = 1'b0;
    cyc(3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
